sqr_rebuild: RTL and testbench

SQR_REBUILD -- requirements
Module: sqr_rebuild

---
 rtl/sqr_rebuild.sv | 110 +++++++++++
 tb/tb_sqr_rebuild.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sqr_rebuild.sv
// rtl/sqr_rebuild.sv - rebuilds a fixed-point radicand from square-root unit outputs
// Sequential shift-add squaring of root, seeded with rem, then rescaled by FBITS.
module sqr_rebuild #(
    parameter int WIDTH = 32,
    parameter int FBITS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] root,
    input  logic [WIDTH-1:0] rem,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] rad,
    output logic             exact,
    output logic             ovf
);

    localparam int AW = 2 * WIDTH + 1;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [AW-1:0]     acc;
    logic [AW-1:0]     mcand;
    logic [WIDTH-1:0]  mplier;
    logic [CW-1:0]     cnt;
    logic              accept;
    logic              exact_next;
    logic              ovf_next;

    // A result sits in IDLE, so the valid cycle also accepts a new start.
    assign accept = start && (state == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) state_next = FIN;
            end
            FIN: begin
                busy       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    generate
        if (FBITS == 0) begin : g_int
            assign exact_next = 1'b1;
        end else begin : g_frac
            assign exact_next = (acc[FBITS-1:0] == '0);
        end
    endgenerate

    assign ovf_next = |acc[AW-1:FBITS+WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            valid  <= 1'b0;
            rad    <= '0;
            exact  <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (accept) begin
                mcand  <= AW'(root);
                mplier <= root;
                acc    <= AW'(rem);
                cnt    <= '0;
            end else if (state == RUN) begin
                if (mplier[0]) acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
            end else if (state == FIN) begin
                rad   <= acc[FBITS+WIDTH-1:FBITS];
                exact <= exact_next;
                ovf   <= ovf_next;
                valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sqr_rebuild.sv
// tb/tb_sqr_rebuild.sv - scoreboard bench for sqr_rebuild
module tb_sqr_rebuild;

    localparam int WIDTH = 32;
    localparam int FBITS = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] root;
    logic [WIDTH-1:0] rem;
    logic             busy;
    logic             valid;
    logic [WIDTH-1:0] rad;
    logic             exact;
    logic             ovf;

    typedef struct {
        logic [WIDTH-1:0] rad;
        logic             exact;
        logic             ovf;
        int               due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    sqr_rebuild #(.WIDTH(WIDTH), .FBITS(FBITS)) dut (
        .clk(clk), .rst(rst), .start(start), .root(root), .rem(rem),
        .busy(busy), .valid(valid), .rad(rad), .exact(exact), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] m);
        logic [2*WIDTH:0] s;
        exp_t e;
        s = (2*WIDTH+1)'(r) * (2*WIDTH+1)'(r) + (2*WIDTH+1)'(m);
        e.rad   = s[FBITS+WIDTH-1:FBITS];
        e.exact = (s[FBITS-1:0] == '0);
        e.ovf   = |s[2*WIDTH:FBITS+WIDTH];
        e.due   = 0;
        return e;
    endfunction

    // Every valid pulse must match the oldest outstanding request, on time.
    always @(negedge clk) begin
        if (!rst && valid) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 64'(valid), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("latency", 64'(cyc), 64'(e.due));
                check("rad", 64'(rad), 64'(e.rad));
                check("exact", 64'(exact), 64'(e.exact));
                check("ovf", 64'(ovf), 64'(e.ovf));
                check("busy_in_valid", 64'(busy), 64'd0);
            end
        end
    end

    // Called just after a posedge; the next edge is the accept edge.
    task automatic issue(input logic [WIDTH-1:0] r, input logic [WIDTH-1:0] m);
        exp_t e;
        start = 1'b1;
        root  = r;
        rem   = m;
        @(posedge clk);
        #1;
        e     = model(r, m);
        e.due = cyc + WIDTH + 1;
        sb.push_back(e);
        start = 1'b0;
        root  = $urandom;
        rem   = $urandom;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    initial begin
        logic [WIDTH-1:0] held;
        int n;
        rst   = 1'b1;
        start = 1'b0;
        root  = '0;
        rem   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_rad", 64'(rad), 64'd0);
        check("rst_exact", 64'(exact), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(32'h0002_0000, 32'h0);
        wait_drain();
        issue(32'h0001_6A09, 32'h0002_8BAF);
        wait_drain();
        issue(32'hFFFF_FFFF, 32'h0);
        wait_drain();
        issue(32'h0, 32'h1);
        wait_drain();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_drain();
        for (int i = 0; i < 6; i++) begin
            issue($urandom, $urandom);
            wait_drain();
        end

        // Starts during RUN must be ignored.
        issue(32'h0003_0000, 32'h0000_1234);
        repeat (5) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            start = 1'b1;
            root  = $urandom;
            rem   = $urandom;
            @(posedge clk);
            #1;
            check("busy_run", 64'(busy), 64'd1);
            start = 1'b0;
            @(posedge clk);
            #1;
        end
        wait_drain();
        repeat (40) @(posedge clk);
        #1;

        // Back-to-back: start in the valid cycle; previous result must hold.
        issue(32'h0000_B504, 32'h0000_7FFF);
        held = model(32'h0000_B504, 32'h0000_7FFF).rad;
        n = 0;
        while (!valid && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("b2b_first_valid", 64'(valid), 64'd1);
        issue(32'h0123_4567, 32'h89AB_CDEF);
        repeat (10) @(posedge clk);
        #1;
        check("hold_rad", 64'(rad), 64'(held));
        check("b2b_busy", 64'(busy), 64'd1);
        wait_drain();

        // Reset in the middle of RUN aborts without a pulse.
        issue(32'h0040_0000, 32'h0000_0055);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_valid", 64'(valid), 64'd0);
        check("abort_rad", 64'(rad), 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (45) @(posedge clk);
        #1;
        issue(32'h0001_6A09, 32'h0002_8BAF);
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
